label_packer: RTL and testbench
===============================

LABEL_PACKER -- requirements
Module: label_packer

Interface
REQ-001 Parameter NUM_PIX, default 1024, pixels per image (32x32, raster order, index = row*32+col); other values are unsupported.
REQ-002 Parameter LBL_W, default 3, width of a valid label value (legal labels 0..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a pass; sampled only in IDLE or DONE.
REQ-006 sram_a  output  10  registered read address into the 1024x8 label SRAM.
REQ-007 sram_wen  output  1  SRAM write enable, active-low; held 1 (read-only) at all times.
REQ-008 sram_q  input  8  SRAM read data; valid in the cycle after the cycle sram_a presented that address.
REQ-009 pack_data  output  8  packed binary byte; bit7 = pixel 8k, bit0 = pixel 8k+7.
REQ-010 pack_addr  output  7  byte index k (0..127) of pack_data.
REQ-011 pack_valid  output  1  pack_data/pack_addr valid; held until accepted.
REQ-012 pack_ready  input  1  consumer accepts the byte when pack_valid and pack_ready are both 1.
REQ-013 area_sel  input  3  label selector for area readout.
REQ-014 area_out  output  11  combinational pixel count of label area_sel; 0 when area_sel=0.
REQ-015 max_label  output  3  largest legal label seen in the current pass.
REQ-016 err  output  1  sticky flag: some sram_q byte exceeded 7 in the current pass.
REQ-017 done  output  1  pass complete; high in DONE only.

Function
REQ-018 FSM states: IDLE, FETCH, EMIT, DONE.
REQ-019 IDLE: start=1 -> FETCH, sram_a<=0, k<=0; area counters, max_label, err cleared.
REQ-020 FETCH: sram_a advances by 1 per cycle through 8k..8k+7; the state issues 8 addresses and captures 8 returned bytes, one per cycle, each one cycle behind its address.
REQ-021 Pixel bit = 1 when the captured byte is nonzero, else 0; the bit for pixel 8k+i is placed at pack_data[7-i].
REQ-022 A captured byte b in 1..7 increments area[b] and updates max_label = max(max_label, b).
REQ-023 A captured byte b > 7 sets err, gives pixel bit 1, and updates no area counter.
REQ-024 The 8th capture moves FETCH -> EMIT, with pack_valid=1 exactly 9 cycles after FETCH entry.
REQ-025 EMIT: pack_data and pack_addr are held stable, no SRAM address advance; pack_ready=0 stalls indefinitely.
REQ-026 EMIT with handshake and k<127 -> k<=k+1, pack_valid<=0, FETCH from sram_a=8(k+1).
REQ-027 EMIT with handshake and k=127 -> DONE, pack_valid<=0, done<=1.
REQ-028 DONE: outputs and statistics held; start=1 behaves as in REQ-019 and clears done.
REQ-029 start outside IDLE/DONE is ignored; no pass restart.
REQ-030 Area counters are 11 bits with no wrap; the maximum count of 1024 fits.
REQ-031 Throughput with pack_ready tied high: one byte per 10 cycles; full pass = 1280 cycles plus 1.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE, sram_a=0, sram_wen=1, pack_data=0, pack_addr=0, pack_valid=0, max_label=0, err=0, done=0, all area counters=0.
REQ-033 Reset mid-pass discards all partial data; no pack_valid until the next start.

Verification
REQ-034 All-zero SRAM, pack_ready=1, start -> 128 bytes 0x00, k 0..127 in order; done=1; max_label=0; area_out=0 for every area_sel.
REQ-035 SRAM[i]=(i%8==0)?3:0 -> every pack_data=0x80; area_out(3)=128; max_label=3; err=0.
REQ-036 SRAM[5]=0x09, rest 0 -> byte k=0 is 0x04; err=1; all areas 0.
REQ-037 pack_ready=0 for 20 cycles at k=5 -> pack_valid held, pack_data/pack_addr stable, sram_a frozen; the byte is accepted on the first pack_ready=1.
REQ-038 reset=0 during FETCH of k=40 -> outputs at reset values immediately; after start, the pass restarts at k=0.
REQ-039 start pulsed during FETCH -> ignored; exactly 128 handshakes, then done=1.

Source files
------------

// File: rtl/label_packer.sv
// Packs a 32x32 label image read from SRAM into 128 binary bytes and gathers per-label areas.
// Latency: pack_valid 9 cycles after FETCH entry; 10 cycles per byte when pack_ready stays high.
// Backpressure: pack_ready low holds the byte and freezes the SRAM address indefinitely.
module label_packer #(
    parameter int NUM_PIX = 1024,
    parameter int LBL_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [9:0]       sram_a,
    output logic             sram_wen,
    input  logic [7:0]       sram_q,
    output logic [7:0]       pack_data,
    output logic [6:0]       pack_addr,
    output logic             pack_valid,
    input  logic             pack_ready,
    input  logic [LBL_W-1:0] area_sel,
    output logic [10:0]      area_out,
    output logic [LBL_W-1:0] max_label,
    output logic             err,
    output logic             done
);

    localparam int NBYTES  = NUM_PIX / 8;
    localparam int MAX_LBL = (1 << LBL_W) - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [6:0]  sh;
    logic [10:0] area [1:MAX_LBL];

    logic             pix;
    logic             big;
    logic [LBL_W-1:0] lbl;
    logic             last_byte;

    assign sram_wen  = 1'b1;
    assign pix       = (sram_q != 8'd0);
    assign big       = (sram_q > 8'(MAX_LBL));
    assign lbl       = sram_q[LBL_W-1:0];
    assign last_byte = (pack_addr == 7'(NBYTES - 1));

    always_comb begin
        area_out = '0;
        if (area_sel != '0)
            area_out = area[area_sel];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh         <= '0;
            sram_a     <= '0;
            pack_data  <= '0;
            pack_addr  <= '0;
            pack_valid <= 1'b0;
            max_label  <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            for (int i = 1; i <= MAX_LBL; i++)
                area[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        cnt       <= '0;
                        sram_a    <= '0;
                        pack_addr <= '0;
                        max_label <= '0;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        for (int i = 1; i <= MAX_LBL; i++)
                            area[i] <= '0;
                    end
                end
                S_FETCH: begin
                    // Address i is issued at cnt=i; its data is captured at cnt=i+1.
                    if (cnt < 4'd7)
                        sram_a <= sram_a + 10'd1;
                    if (cnt != 4'd0) begin
                        sh <= {sh[5:0], pix};
                        if (big) begin
                            err <= 1'b1;
                        end else if (pix) begin
                            area[lbl] <= area[lbl] + 11'd1;
                            if (lbl > max_label)
                                max_label <= lbl;
                        end
                    end
                    if (cnt == 4'd8) begin
                        pack_data  <= {sh, pix};
                        pack_valid <= 1'b1;
                        state      <= S_EMIT;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (pack_ready) begin
                        pack_valid <= 1'b0;
                        if (last_byte) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            pack_addr <= pack_addr + 7'd1;
                            sram_a    <= sram_a + 10'd1;
                            state     <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_label_packer.sv
// Directed bench for label_packer: SRAM model with one-cycle read latency, pass-level checks.
module tb_label_packer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  sram_a;
    logic        sram_wen;
    logic [7:0]  sram_q;
    logic [7:0]  pack_data;
    logic [6:0]  pack_addr;
    logic        pack_valid;
    logic        pack_ready;
    logic [2:0]  area_sel;
    logic [10:0] area_out;
    logic [2:0]  max_label;
    logic        err;
    logic        done;

    logic [7:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    label_packer #(.NUM_PIX(1024), .LBL_W(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .sram_a(sram_a), .sram_wen(sram_wen), .sram_q(sram_q),
        .pack_data(pack_data), .pack_addr(pack_addr), .pack_valid(pack_valid),
        .pack_ready(pack_ready), .area_sel(area_sel), .area_out(area_out),
        .max_label(max_label), .err(err), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[sram_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[7-i] = (mem[8*k+i] != 8'd0);
        return b;
    endfunction

    // Runs one full pass from start; optional stall of 20 cycles at byte stall_k and a stray start at cycle pulse_cyc.
    task automatic run_pass(input int stall_k, input int pulse_cyc,
                            output int nb, output int cyc, output int fv, output logic [7:0] fb);
        int stall;
        logic [9:0] a_snap;
        bit fin;
        nb = 0; cyc = 0; fv = -1; fb = 8'h00; stall = 0; fin = 0; a_snap = '0;
        pack_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_cyc);
            if (done) begin
                fin = 1;
            end else if (pack_valid) begin
                if (fv < 0) begin
                    fv = cyc;
                    fb = pack_data;
                end
                chk("pack_addr", 32'(pack_addr), 32'(nb));
                chk("pack_data", 32'(pack_data), 32'(exp_byte(nb)));
                if (nb == stall_k && stall < 20) begin
                    if (stall == 0) a_snap = sram_a;
                    else chk("sram_a_frozen", 32'(sram_a), 32'(a_snap));
                    pack_ready = 1'b0;
                    stall++;
                end else begin
                    pack_ready = 1'b1;
                    nb++;
                end
            end
        end
        start = 1'b0;
        if (!fin) chk("pass_timeout_done", 32'(done), 32'd1);
        pack_ready = 1'b0;
    endtask

    initial begin
        int nb, cyc, fv, vseen;
        logic [7:0] fb;
        reset = 1'b0; start = 1'b0; pack_ready = 1'b0; area_sel = 3'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);

        chk("rst_sram_a", 32'(sram_a), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd1);
        chk("rst_valid", 32'(pack_valid), 32'd0);
        chk("rst_data", 32'(pack_data), 32'd0);
        chk("rst_addr", 32'(pack_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_max", 32'(max_label), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // All-zero image
        run_pass(-1, -1, nb, cyc, fv, fb);
        chk("zero_bytes", 32'(nb), 32'd128);
        chk("zero_cycles", 32'(cyc), 32'd1280);
        chk("zero_first_valid", 32'(fv), 32'd9);
        chk("zero_first_byte", 32'(fb), 32'h00);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_max", 32'(max_label), 32'd0);
        chk("zero_err", 32'(err), 32'd0);
        chk("zero_wen", 32'(sram_wen), 32'd1);
        for (int s = 0; s < 8; s++) begin
            area_sel = 3'(s);
            #1 chk("zero_area", 32'(area_out), 32'd0);
        end

        // Label 3 at the first pixel of every byte
        for (int i = 0; i < 1024; i++) mem[i] = (i % 8 == 0) ? 8'd3 : 8'd0;
        @(negedge clk);
        run_pass(-1, -1, nb, cyc, fv, fb);
        chk("l3_first_byte", 32'(fb), 32'h80);
        chk("l3_bytes", 32'(nb), 32'd128);
        area_sel = 3'd3;
        #1 chk("l3_area3", 32'(area_out), 32'd128);
        area_sel = 3'd1;
        #1 chk("l3_area1", 32'(area_out), 32'd0);
        chk("l3_max", 32'(max_label), 32'd3);
        chk("l3_err", 32'(err), 32'd0);

        // Out-of-range byte at pixel 5
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        mem[5] = 8'h09;
        @(negedge clk);
        run_pass(-1, -1, nb, cyc, fv, fb);
        chk("big_first_byte", 32'(fb), 32'h04);
        chk("big_err", 32'(err), 32'd1);
        chk("big_max", 32'(max_label), 32'd0);
        for (int s = 0; s < 8; s++) begin
            area_sel = 3'(s);
            #1 chk("big_area", 32'(area_out), 32'd0);
        end

        // Backpressure: 20-cycle stall at k=5 on a mixed image
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 11);
        @(negedge clk);
        run_pass(5, -1, nb, cyc, fv, fb);
        chk("stall_bytes", 32'(nb), 32'd128);
        chk("stall_cycles", 32'(cyc), 32'd1300);
        chk("stall_first_byte", 32'(fb), 32'h7F);
        chk("stall_err", 32'(err), 32'd1);
        chk("stall_max", 32'(max_label), 32'd7);

        // Stray start during FETCH must not restart the pass
        for (int i = 0; i < 1024; i++) mem[i] = (i % 8 == 0) ? 8'd3 : 8'd0;
        @(negedge clk);
        run_pass(-1, 3, nb, cyc, fv, fb);
        chk("stray_bytes", 32'(nb), 32'd128);
        chk("stray_cycles", 32'(cyc), 32'd1280);
        chk("stray_done", 32'(done), 32'd1);

        // Reset during FETCH of k=40
        pack_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; cyc = 0;
        while (nb < 40 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (pack_valid) nb++;
        end
        chk("k40_reached", 32'(nb), 32'd40);
        repeat (3) @(negedge clk);
        chk("k40_in_fetch_addr", 32'(pack_addr), 32'd40);
        reset = 1'b0;
        area_sel = 3'd3;
        #1;
        chk("mid_rst_sram_a", 32'(sram_a), 32'd0);
        chk("mid_rst_valid", 32'(pack_valid), 32'd0);
        chk("mid_rst_addr", 32'(pack_addr), 32'd0);
        chk("mid_rst_data", 32'(pack_data), 32'd0);
        chk("mid_rst_area3", 32'(area_out), 32'd0);
        chk("mid_rst_max", 32'(max_label), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        vseen = 0;
        repeat (30) begin
            @(negedge clk);
            if (pack_valid) vseen++;
        end
        chk("post_rst_no_valid", 32'(vseen), 32'd0);
        run_pass(-1, -1, nb, cyc, fv, fb);
        chk("restart_bytes", 32'(nb), 32'd128);
        chk("restart_first_byte", 32'(fb), 32'h80);
        area_sel = 3'd3;
        #1 chk("restart_area3", 32'(area_out), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
